// File: rtl/window_fetch.sv
// Sliding-window fetch: walks a K_W-column window over N_BUF_X circular column buffers and streams one beat per (x,y,cw).
// Optional stall counter is compiled in with `define WINDOW_FETCH_STALL_CNT_EN.
module window_fetch #(
  parameter int N_BUF_X    = 5,
  parameter int K_W        = 3,
  parameter int B_DSHAPE   = 48,
  parameter int B_COORD    = 8,
  parameter int B_BUF_ADDR = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [B_DSHAPE-1:0]              dshape,
  input  logic [B_COORD-1:0]               cols_done,
  output logic [N_BUF_X*B_BUF_ADDR-1:0]    rd_addr,
  input  logic [DATA_WIDTH*N_BUF_X-1:0]    buf_do,
  output logic [DATA_WIDTH*K_W-1:0]        m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast,
  output logic [B_COORD-1:0]               rd_x,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      stall_cnt,
  output logic [1:0]                       fsm_state
);

  localparam int XMW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam int BW  = DATA_WIDTH * K_W;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [15:0]           w_q, h_q, x_q, y_q;
  logic [9:0]            nc_q, cw_q;
  logic [B_BUF_ADDR-1:0] col_words_q, offset_q;
  logic [B_BUF_ADDR-1:0] base_q [N_BUF_X];
  logic [XMW-1:0]        xm_q, if_xm_q;
  logic                  inflight_q, if_last_q;
  logic [BW:0]           fifo_mem [2];
  logic                  fifo_wp_q, fifo_rp_q;
  logic [1:0]            fifo_cnt_q, occ_next;
  logic [BW-1:0]         beat_data;
  logic [31:0]           dims_prod;
  logic                  start_acc, issue, pop, degenerate, cols_ok;
  logic                  y_last, cw_last, col_end, last_x, drain_empty;
  logic                  unused_bits;

  assign unused_bits = ^dshape[5:0];
  assign dims_prod   = {16'd0, dshape[31:16]} * {22'd0, dshape[15:6]};

  assign start_acc   = (state_q == IDLE) && start;
  assign degenerate  = (nc_q == 10'd0) || (h_q == 16'd0) || (w_q < 16'(K_W));
  assign cols_ok     = ({1'b0, x_q} + 17'(K_W)) <= 17'(cols_done);
  assign y_last      = (y_q == h_q - 16'd1);
  assign cw_last     = (cw_q == nc_q - 10'd1);
  assign col_end     = y_last && cw_last;
  assign last_x      = (x_q == w_q - 16'(K_W));
  assign drain_empty = (fifo_cnt_q == 2'd0) && !inflight_q;

  // Output stream: a beat transfers on m_tvalid & m_tready; while m_tvalid is high and
  // m_tready low the FIFO head is not popped, so m_tdata/m_tlast stay stable.
  assign pop      = m_tvalid && m_tready;
  assign occ_next = fifo_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
  assign m_tvalid = (fifo_cnt_q != 2'd0);
  assign m_tdata  = m_tvalid ? fifo_mem[fifo_rp_q][BW-1:0] : '0;
  assign m_tlast  = m_tvalid ? fifo_mem[fifo_rp_q][BW] : 1'b0;
  assign rd_x     = B_COORD'(x_q);
  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = WAIT;
      WAIT:  if (degenerate) state_d = DRAIN;
             else if (cols_ok) state_d = RUN;
      RUN:   if (issue && col_end) state_d = last_x ? DRAIN : WAIT;
      DRAIN: if (drain_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read may issue only if the FIFO still has room once this cycle's pop and the
  // in-flight read are accounted for; counting the pop keeps the stream at full rate.
  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DRAIN) && drain_empty;
    issue = (state_q == RUN) && (occ_next < 2'd2);
  end

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < N_BUF_X; i++)
      rd_addr[i*B_BUF_ADDR +: B_BUF_ADDR] = base_q[i] + offset_q;
  end

  always_comb begin
    int sel;
    beat_data = '0;
    for (int k = 0; k < K_W; k++) begin
      sel = int'(if_xm_q) + k;
      if (sel >= N_BUF_X) sel = sel - N_BUF_X;
      beat_data[k*DATA_WIDTH +: DATA_WIDTH] = buf_do[sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      h_q         <= '0;
      nc_q        <= '0;
      col_words_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cw_q        <= '0;
      xm_q        <= '0;
      offset_q    <= '0;
      inflight_q  <= 1'b0;
      if_xm_q     <= '0;
      if_last_q   <= 1'b0;
      for (int i = 0; i < N_BUF_X; i++) base_q[i] <= '0;
    end else begin
      inflight_q <= issue;
      if_xm_q    <= xm_q;
      if_last_q  <= col_end;
      if (start_acc) begin
        w_q         <= dshape[47:32];
        h_q         <= dshape[31:16];
        nc_q        <= dshape[15:6];
        col_words_q <= dims_prod[B_BUF_ADDR-1:0];
        x_q         <= '0;
        y_q         <= '0;
        cw_q        <= '0;
        xm_q        <= '0;
        offset_q    <= '0;
        for (int i = 0; i < N_BUF_X; i++) base_q[i] <= '0;
      end else if (issue) begin
        if (col_end) begin
          y_q      <= '0;
          cw_q     <= '0;
          offset_q <= '0;
          if (!last_x) begin
            // The buffer leaving the window gets refilled one column further on.
            x_q  <= x_q + 16'd1;
            xm_q <= (xm_q == XMW'(N_BUF_X - 1)) ? '0 : xm_q + XMW'(1);
            for (int i = 0; i < N_BUF_X; i++)
              if (xm_q == XMW'(i)) base_q[i] <= base_q[i] + col_words_q;
          end
        end else begin
          offset_q <= offset_q + B_BUF_ADDR'(1);
          if (cw_last) begin
            cw_q <= '0;
            y_q  <= y_q + 16'd1;
          end else begin
            cw_q <= cw_q + 10'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      if (inflight_q) begin
        fifo_mem[fifo_wp_q] <= {if_last_q, beat_data};
        fifo_wp_q           <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef WINDOW_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (start_acc) stall_q <= '0;
    else if (((state_q == WAIT) || (m_tvalid && !m_tready)) && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_window_fetch.sv
// Bench for window_fetch: directed frames, a modelled buffer array, and a scoreboard of expected window beats.
module tb_window_fetch;
  localparam int N  = 5;
  localparam int KW = 3;
  localparam int DW = 64;
  localparam int BA = 10;
  localparam int W  = DW * KW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [47:0]     dshape = '0;
  logic [7:0]      cols_done = '0;
  logic [N*BA-1:0] rd_addr;
  logic [DW*N-1:0] buf_do = '0;
  logic [DW*KW-1:0] m_tdata;
  logic            m_tvalid, m_tlast;
  logic            m_tready = 1'b1;
  logic [7:0]      rd_x;
  logic            busy, done;
  logic [31:0]     stall_cnt;
  logic [1:0]      fsm_state;

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int done_cnt = 0;
  int stall_seen = 0;
  bit stall_en = 1'b0;
  bit x5_en = 1'b0;
  bit x5_seen = 1'b0;
  logic [W-1:0] exp_q[$];
  int beat_cyc[$];

  window_fetch dut (
    .clk(clk), .rst(rst), .start(start), .dshape(dshape), .cols_done(cols_done),
    .rd_addr(rd_addr), .buf_do(buf_do), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .rd_x(rd_x), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] mem_word(input int b, input int a);
    return (64'(b) << 56) | 64'(a & 1023);
  endfunction

  // buffer array model: one-cycle read latency
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      buf_do[i*DW +: DW] <= mem_word(i, int'(rd_addr[i*BA +: BA]));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && m_tvalid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
      end else if (m_tready) begin
        check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        beat_cyc.push_back(cycle);
      end else begin
        check("hold_data", {m_tlast, m_tdata}, exp_q[0]);
      end
    end
    if (done) done_cnt++;
    if (stall_en && ((fsm_state == 2'd1) || (m_tvalid && !m_tready))) stall_seen++;
    if (x5_en && !x5_seen && rd_x == 8'd5) begin
      x5_seen = 1'b1;
      check("rd_addr0_at_x5", 256'(rd_addr[BA-1:0]), 256'd8);
    end
  end

  // expected beats of one frame, from buffer geometry alone
  task automatic push_frame(input int w, input int h, input int c);
    int nc, cwords, b, cnt, a;
    logic [W-1:0] e;
    nc = c >> 6;
    cwords = (h * nc) & 1023;
    for (int x = 0; x <= w - KW; x++)
      for (int y = 0; y < h; y++)
        for (int cw = 0; cw < nc; cw++) begin
          e = '0;
          for (int k = 0; k < KW; k++) begin
            b = (x + k) % N;
            cnt = 0;
            for (int xp = 0; xp < x; xp++) if (xp % N == b) cnt++;
            a = (cnt * cwords + y * nc + cw) & 1023;
            e[k*DW +: DW] = mem_word(b, a);
          end
          e[W-1] = (y == h - 1) && (cw == nc - 1);
          exp_q.push_back(e);
        end
  endtask

  task automatic do_start(input int w, input int h, input int c);
    @(posedge clk);
    #1;
    dshape = {16'(w), 16'(h), 16'(c)};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 256'(seen), 256'd1);
  endtask

  task automatic run_basic(input string name);
    int d0, g1, g2;
    m_tready = 1'b1;
    cols_done = 8'd4;
    beat_cyc.delete();
    push_frame(4, 2, 64);
    d0 = done_cnt;
    do_start(4, 2, 64);
    wait_done(name, 200);
    repeat (3) @(negedge clk);
    check({name, "_beats"}, 256'(beat_cyc.size()), 256'd4);
    g1 = (beat_cyc.size() >= 2) ? beat_cyc[1] - beat_cyc[0] : -1;
    g2 = (beat_cyc.size() >= 4) ? beat_cyc[3] - beat_cyc[2] : -1;
    check({name, "_gap_col0"}, 256'(g1), 256'd1);
    check({name, "_gap_col1"}, 256'(g2), 256'd1);
    check({name, "_done_once"}, 256'(done_cnt - d0), 256'd1);
    check({name, "_q_empty"}, 256'(exp_q.size()), 256'd0);
    check({name, "_busy_after"}, 256'(busy), 256'd0);
  endtask

  initial begin
    int d0, exp_stall;
    bit pat_stop;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 256'(m_tvalid), 256'd0);
    check("rst_tlast", 256'(m_tlast), 256'd0);
    check("rst_tdata", 256'(m_tdata), 256'd0);
    check("rst_rd_addr", 256'(rd_addr), 256'd0);
    check("rst_rd_x", 256'(rd_x), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_stall_cnt", 256'(stall_cnt), 256'd0);
    check("rst_state", 256'(fsm_state), 256'd0);
    rst = 1'b0;

    // basic 4x2 frame
    run_basic("basic");

    // cols_done stepped while the frame waits
    m_tready = 1'b1;
    cols_done = 8'd0;
    beat_cyc.delete();
    push_frame(4, 2, 64);
    do_start(4, 2, 64);
    repeat (8) @(posedge clk);
    #1;
    check("step_no_beat_before_3", 256'(beat_cyc.size()), 256'd0);
    check("step_rd_x_0", 256'(rd_x), 256'd0);
    check("step_busy", 256'(busy), 256'd1);
    cols_done = 8'd3;
    repeat (10) @(posedge clk);
    #1;
    check("step_col0_beats", 256'(beat_cyc.size()), 256'd2);
    check("step_rd_x_1", 256'(rd_x), 256'd1);
    check("step_waiting", 256'(fsm_state), 256'd1);
    cols_done = 8'd4;
    wait_done("step", 200);
    repeat (2) @(negedge clk);
    check("step_total_beats", 256'(beat_cyc.size()), 256'd4);
    check("step_q_empty", 256'(exp_q.size()), 256'd0);

    // backpressure pattern 1,0,0,1
    cols_done = 8'd4;
    beat_cyc.delete();
    push_frame(4, 2, 64);
    do_start(4, 2, 64);
    stall_seen = 0;
    stall_en = 1'b1;
    pat_stop = 1'b0;
    fork
      begin
        wait_done("bp", 300);
        pat_stop = 1'b1;
      end
      begin
        int p;
        p = 0;
        while (!pat_stop) begin
          m_tready = (p % 4 == 0) || (p % 4 == 3);
          @(posedge clk);
          #1;
          p++;
        end
      end
    join
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    stall_en = 1'b0;
    check("bp_beats", 256'(beat_cyc.size()), 256'd4);
    check("bp_q_empty", 256'(exp_q.size()), 256'd0);
`ifdef WINDOW_FETCH_STALL_CNT_EN
    exp_stall = stall_seen;
`else
    exp_stall = 0;
`endif
    check("bp_stall_cnt", 256'(stall_cnt), 256'(exp_stall));

    // 8x4x128 frame: base advance and slot wrap
    m_tready = 1'b1;
    cols_done = 8'd8;
    beat_cyc.delete();
    push_frame(8, 4, 128);
    x5_seen = 1'b0;
    x5_en = 1'b1;
    do_start(8, 4, 128);
    wait_done("wide", 2000);
    repeat (2) @(negedge clk);
    x5_en = 1'b0;
    check("wide_beats", 256'(beat_cyc.size()), 256'd48);
    check("wide_q_empty", 256'(exp_q.size()), 256'd0);
    check("wide_x5_seen", 256'(x5_seen), 256'd1);

    // degenerate frame, start repeated while busy
    beat_cyc.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    dshape = {16'd4, 16'd2, 16'd32};
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("degen_busy_c1", 256'(busy), 256'd1);
    check("degen_done_c1", 256'(done), 256'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("degen_done_c2", 256'(done), 256'd1);
    repeat (10) @(negedge clk);
    check("degen_done_once", 256'(done_cnt - d0), 256'd1);
    check("degen_no_beats", 256'(beat_cyc.size()), 256'd0);
    check("degen_idle", 256'(busy), 256'd0);

    // reset mid-frame, then the basic frame again
    m_tready = 1'b1;
    cols_done = 8'd4;
    push_frame(4, 2, 64);
    do_start(4, 2, 64);
    begin
      bit seen_v;
      seen_v = 1'b0;
      for (int i = 0; i < 50 && !seen_v; i++) begin
        @(negedge clk);
        if (m_tvalid) seen_v = 1'b1;
      end
      check("midrst_valid_seen", 256'(seen_v), 256'd1);
    end
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_tvalid", 256'(m_tvalid), 256'd0);
    check("midrst_busy", 256'(busy), 256'd0);
    check("midrst_tdata", 256'(m_tdata), 256'd0);
    check("midrst_rd_addr", 256'(rd_addr), 256'd0);
    check("midrst_rd_x", 256'(rd_x), 256'd0);
    check("midrst_stall", 256'(stall_cnt), 256'd0);
    rst = 1'b0;
    run_basic("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got cycle %0d expected completion", cycle);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
